// File: rtl/az_sequencer.sv
// Auto-zero sequencer: alternates the azmux between signal (HI) and zero (LO)
// inputs, settling then starting the ADC and collecting the result each phase.
module az_sequencer #(
  parameter int         CNT_W  = 24,
  parameter logic [2:0] HI_SEL = 3'b001,
  parameter logic [2:0] LO_SEL = 3'b110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] settle_count,
  input  logic [CNT_W-1:0] timeout_count,
  input  logic             adc_done,
  output logic [3:0]       azmux_out,
  output logic             sw_pc_ctl,
  output logic             adc_start,
  output logic             sample_valid,
  output logic             sample_hi,
  output logic             err_timeout,
  output logic [2:0]       state_mon
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HI_SETTLE = 3'd1,
    S_HI_MEAS   = 3'd2,
    S_LO_SETTLE = 3'd3,
    S_LO_MEAS   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [3:0]       azmux_q, azmux_d;
  logic             sw_q, sw_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             hi_q, hi_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] settle_eff_s, tmo_eff_s, cnt_inc_s;
  logic             settle_hit_s, tmo_hit_s, done_ok_s;

  // A zero count behaves as one clock; compare against count-1 so the max value never overflows.
  always_comb begin
    settle_eff_s = (settle_q == CNT_ZERO) ? CNT_ONE : settle_q;
    tmo_eff_s    = (tmo_q == CNT_ZERO) ? CNT_ONE : tmo_q;
    settle_hit_s = (cnt_q >= (settle_eff_s - CNT_ONE));
    tmo_hit_s    = (cnt_q >= (tmo_eff_s - CNT_ONE));
    cnt_inc_s    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_ONE);
    done_ok_s    = adc_done && !start_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    hi_d     = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_HI_SETTLE;
          settle_d = settle_count;
          tmo_d    = timeout_count;
          err_d    = 1'b0;
          cnt_d    = CNT_ZERO;
        end
        S_HI_SETTLE, S_LO_SETTLE: begin
          if (settle_hit_s) begin
            state_d = (state_q == S_HI_SETTLE) ? S_HI_MEAS : S_LO_MEAS;
            start_d = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_HI_MEAS, S_LO_MEAS: begin
          // Done wins over a coincident timeout; either way move on to the other phase.
          if (done_ok_s) begin
            state_d = (state_q == S_HI_MEAS) ? S_LO_SETTLE : S_HI_SETTLE;
            valid_d = 1'b1;
            hi_d    = (state_q == S_HI_MEAS);
            cnt_d   = CNT_ZERO;
          end else if (tmo_hit_s) begin
            state_d = (state_q == S_HI_MEAS) ? S_LO_SETTLE : S_HI_SETTLE;
            err_d   = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Mux outputs follow the next state so they switch on the transition edge.
  always_comb begin
    case (state_d)
      S_HI_SETTLE, S_HI_MEAS: begin
        azmux_d = {1'b1, HI_SEL};
        sw_d    = 1'b1;
      end
      S_LO_SETTLE, S_LO_MEAS: begin
        azmux_d = {1'b1, LO_SEL};
        sw_d    = 1'b0;
      end
      default: begin
        azmux_d = 4'b0000;
        sw_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      settle_q <= CNT_ZERO;
      tmo_q    <= CNT_ZERO;
      azmux_q  <= 4'b0000;
      sw_q     <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      hi_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      azmux_q  <= azmux_d;
      sw_q     <= sw_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
    end
  end

  assign azmux_out    = azmux_q;
  assign sw_pc_ctl    = sw_q;
  assign adc_start    = start_q;
  assign sample_valid = valid_q;
  assign sample_hi    = hi_q;
  assign err_timeout  = err_q;
  assign state_mon    = state_q;

endmodule

// File: tb/tb_az_sequencer.sv
// Directed self-checking bench for az_sequencer; each task drives one scenario
// and compares outputs sampled 1ns after the rising edge.
module tb_az_sequencer;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [CNT_W-1:0] settle_count;
  logic [CNT_W-1:0] timeout_count;
  logic             adc_done;
  logic [3:0]       azmux_out;
  logic             sw_pc_ctl;
  logic             adc_start;
  logic             sample_valid;
  logic             sample_hi;
  logic             err_timeout;
  logic [2:0]       state_mon;

  int checks = 0;
  int errors = 0;

  az_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .settle_count(settle_count), .timeout_count(timeout_count),
    .adc_done(adc_done), .azmux_out(azmux_out), .sw_pc_ctl(sw_pc_ctl),
    .adc_start(adc_start), .sample_valid(sample_valid), .sample_hi(sample_hi),
    .err_timeout(err_timeout), .state_mon(state_mon)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until adc_start is seen or the budget runs out; k = clocks taken.
  task automatic wait_start(input int limit, output int k);
    k = 0;
    while (adc_start !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; adc_done = 1'b0;
    settle_count = 24'd10; timeout_count = 24'd50;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if ({azmux_out, sw_pc_ctl, adc_start, sample_valid, sample_hi, err_timeout, state_mon} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got az=%b sw=%b st=%b v=%b hi=%b err=%b mon=%0d expected all 0",
                 i, azmux_out, sw_pc_ctl, adc_start, sample_valid, sample_hi, err_timeout, state_mon);
      end
      tick();
    end
  endtask

  task automatic test_normal();
    int k;
    logic exp_hi;
    settle_count = 24'd10; timeout_count = 24'd50; enable = 1'b1;
    tick();
    checks++;
    if (azmux_out !== 4'b1001 || sw_pc_ctl !== 1'b1 || state_mon !== 3'd1) begin
      errors++;
      $display("FAIL normal_entry: got az=%b sw=%b mon=%0d expected 1001 1 1", azmux_out, sw_pc_ctl, state_mon);
    end
    for (int p = 0; p < 4; p++) begin
      exp_hi = (p % 2 == 0);
      wait_start(40, k);
      checks++;
      if (k !== 10) begin
        errors++;
        $display("FAIL normal_settle p%0d: got %0d clocks expected 10", p, k);
      end
      checks++;
      if (state_mon !== (exp_hi ? 3'd2 : 3'd4) || azmux_out !== (exp_hi ? 4'b1001 : 4'b1110)) begin
        errors++;
        $display("FAIL normal_meas p%0d: got mon=%0d az=%b", p, state_mon, azmux_out);
      end
      tick();
      checks++;
      if (adc_start !== 1'b0) begin
        errors++;
        $display("FAIL normal_start_pulse p%0d: got %b expected 0", p, adc_start);
      end
      repeat (3) tick();
      adc_done = 1'b1;
      tick();
      adc_done = 1'b0;
      checks++;
      if (sample_valid !== 1'b1 || sample_hi !== exp_hi) begin
        errors++;
        $display("FAIL normal_sample p%0d: got v=%b hi=%b expected 1 %b", p, sample_valid, sample_hi, exp_hi);
      end
      checks++;
      if (azmux_out !== (exp_hi ? 4'b1110 : 4'b1001) || sw_pc_ctl !== !exp_hi ||
          state_mon !== (exp_hi ? 3'd3 : 3'd1) || err_timeout !== 1'b0) begin
        errors++;
        $display("FAIL normal_switch p%0d: got az=%b sw=%b mon=%0d err=%b", p, azmux_out, sw_pc_ctl, state_mon, err_timeout);
      end
    end
    enable = 1'b0;
    tick();
    checks++;
    if (state_mon !== 3'd0 || azmux_out !== 4'b0000 || sw_pc_ctl !== 1'b0) begin
      errors++;
      $display("FAIL normal_disable: got mon=%0d az=%b sw=%b expected 0 0000 0", state_mon, azmux_out, sw_pc_ctl);
    end
  endtask

  task automatic test_timeout();
    int k;
    settle_count = 24'd10; timeout_count = 24'd20; enable = 1'b1;
    tick();
    wait_start(40, k);
    checks++;
    if (k !== 10) begin
      errors++;
      $display("FAIL tmo_settle: got %0d expected 10", k);
    end
    for (int i = 1; i < 20; i++) begin
      tick();
      checks++;
      if (err_timeout !== 1'b0 || sample_valid !== 1'b0 || state_mon !== 3'd2) begin
        errors++;
        $display("FAIL tmo_wait cyc %0d: got err=%b v=%b mon=%0d expected 0 0 2", i, err_timeout, sample_valid, state_mon);
      end
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || sample_valid !== 1'b0 || state_mon !== 3'd3 || azmux_out !== 4'b1110) begin
      errors++;
      $display("FAIL tmo_expire: got err=%b v=%b mon=%0d az=%b expected 1 0 3 1110",
               err_timeout, sample_valid, state_mon, azmux_out);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (err_timeout !== 1'b1 || state_mon !== 3'd0) begin
      errors++;
      $display("FAIL tmo_sticky_idle: got err=%b mon=%0d expected 1 0", err_timeout, state_mon);
    end
  endtask

  task automatic test_enable_drop();
    int k;
    settle_count = 24'd10; timeout_count = 24'd50; enable = 1'b1;
    tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_err_clear: got %b expected 0", err_timeout);
    end
    wait_start(40, k);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    checks++;
    if (state_mon !== 3'd0 || azmux_out !== 4'b0000 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got mon=%0d az=%b v=%b expected 0 0000 0", state_mon, azmux_out, sample_valid);
    end
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sample_valid !== 1'b0 || state_mon !== 3'd0) begin
        errors++;
        $display("FAIL drop_late_done cyc %0d: got v=%b mon=%0d expected 0 0", i, sample_valid, state_mon);
      end
      tick();
    end
  endtask

  task automatic test_zero_counts();
    settle_count = 24'd0; timeout_count = 24'd0; enable = 1'b1;
    tick();
    tick();
    checks++;
    if (adc_start !== 1'b1 || state_mon !== 3'd2) begin
      errors++;
      $display("FAIL zero_settle: got st=%b mon=%0d expected 1 2", adc_start, state_mon);
    end
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    checks++;
    if (err_timeout !== 1'b1 || sample_valid !== 1'b0 || state_mon !== 3'd3) begin
      errors++;
      $display("FAIL zero_timeout: got err=%b v=%b mon=%0d expected 1 0 3", err_timeout, sample_valid, state_mon);
    end
    tick();
    tick();
    checks++;
    if (state_mon !== 3'd1 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_lo_loop: got mon=%0d v=%b expected 1 0", state_mon, sample_valid);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_settle_change();
    int k;
    settle_count = 24'd10; timeout_count = 24'd50; enable = 1'b1;
    tick();
    wait_start(80, k);
    settle_count = 24'd40;
    tick();
    adc_done = 1'b1;
    tick();
    adc_done = 1'b0;
    wait_start(80, k);
    checks++;
    if (k !== 10) begin
      errors++;
      $display("FAIL change_running: got %0d clocks expected 10", k);
    end
    enable = 1'b0;
    tick(); tick();
    enable = 1'b1;
    tick();
    wait_start(80, k);
    checks++;
    if (k !== 40) begin
      errors++;
      $display("FAIL change_relatched: got %0d clocks expected 40", k);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    settle_count = 24'd10; timeout_count = 24'd20; enable = 1'b1;
    repeat (15) tick();
    reset = 1'b1;
    adc_done = 1'b1;
    tick();
    checks++;
    if (state_mon !== 3'd0 || azmux_out !== 4'b0000 || sample_valid !== 1'b0 || adc_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got mon=%0d az=%b v=%b st=%b expected 0 0000 0 0",
               state_mon, azmux_out, sample_valid, adc_start);
    end
    reset = 1'b0;
    adc_done = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_enable_drop();
    test_zero_counts();
    test_settle_change();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
